// File: rtl/calc_entry.sv
// calc_entry: keypad entry controller in front of the combinational calc core.
// Optional feature macro CALC_ENTRY_CHAIN_EN: an operator key in RESULT chains the result into A.
//
// Handshake (parity toggle): a request is launched by inverting the req bit data_input[52];
// the request word is stable from the cycle after that toggle. The core acknowledges by
// driving flag_out to ~req; while flag_out == req the controller holds in WAIT. The inf/ovf
// bits [53]/[54] are parity toggles too: a returned flag differing from the stored copy
// signals the event, and the stored copy is updated to match.

module calc_entry #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [8*DIGITS+6:0]   data_input,
  input  logic [4*DIGITS-1:0]   data_output,
  input  logic                  flag_out,
  input  logic                  flag_inf_out,
  input  logic                  flag_ovf_out,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  err_inf,
  output logic                  err_ovf,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] BLANK = {DIGITS{4'hF}};
  localparam logic [W-1:0] ZERO  = {{(DIGITS-1){4'hF}}, 4'h0};

  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [3:0]     op_q, op_d;
  logic           req_q, req_d;
  logic           inf_q, inf_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   disp_q, disp_d;
  logic           err_inf_q, err_inf_d;
  logic           err_ovf_q, err_ovf_d;
  logic           busy_q, busy_d;

  logic           key_is_digit;
  logic           key_is_op;
  logic [W-1:0]   cur_opnd;
  logic           cur_full;
  logic [W-1:0]   cur_next;

  assign key_is_digit = (key_code <= 4'd9);
  assign key_is_op    = (key_code >= 4'hA) && (key_code <= 4'hD);

  // Operand currently being typed; a lone 0 absorbs further zeros.
  assign cur_opnd = (state_q == ST_ENTER_B) ? b_q : a_q;
  assign cur_full = (cur_opnd[W-1 -: 4] != 4'hF);
  assign cur_next = ((cur_opnd == ZERO) && (key_code == 4'h0)) ? cur_opnd
                                                               : {cur_opnd[W-5:0], key_code};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    req_d     = req_q;
    inf_d     = inf_q;
    ovf_d     = ovf_q;
    disp_d    = disp_q;
    err_inf_d = err_inf_q;
    err_ovf_d = err_ovf_q;
    busy_d    = busy_q;

    if (state_q == ST_REQ) begin
      req_d   = ~req_q;
      state_d = ST_WAIT;
      busy_d  = 1'b1;
    end else if (state_q == ST_WAIT) begin
      if (flag_out != req_q) begin
        disp_d = data_output;
        if (flag_inf_out != inf_q) begin
          err_inf_d = 1'b1;
          inf_d     = flag_inf_out;
        end
        if (flag_ovf_out != ovf_q) begin
          err_ovf_d = 1'b1;
          ovf_d     = flag_ovf_out;
        end
        state_d = ST_RESULT;
        busy_d  = 1'b0;
      end
    end else if (key_valid) begin
      if (key_code == KEY_CLR) begin
        // Everything back to reset values except the handshake parity bits.
        state_d   = ST_ENTER_A;
        a_d       = BLANK;
        b_d       = BLANK;
        op_d      = 4'h0;
        disp_d    = ZERO;
        err_inf_d = 1'b0;
        err_ovf_d = 1'b0;
        busy_d    = 1'b0;
      end else if ((state_q == ST_ENTER_A) || (state_q == ST_ENTER_B)) begin
        if (key_is_digit) begin
          if (!cur_full) begin
            if (state_q == ST_ENTER_A) a_d = cur_next;
            else                       b_d = cur_next;
            disp_d = cur_next;
          end
        end else if (key_is_op) begin
          if ((state_q == ST_ENTER_A) && (a_q != BLANK)) begin
            op_d    = key_code;
            state_d = ST_ENTER_B;
          end else if ((state_q == ST_ENTER_B) && (b_q == BLANK)) begin
            op_d = key_code;
          end
        end else if (key_code == KEY_EQ) begin
          if ((state_q == ST_ENTER_B) && (b_q != BLANK)) begin
            state_d = ST_REQ;
            busy_d  = 1'b1;
          end
        end
      end else if (state_q == ST_RESULT) begin
        if (key_is_digit) begin
          // Fresh calculation; the old result stays on the display until the next digit.
          a_d       = {{(DIGITS-1){4'hF}}, key_code};
          b_d       = BLANK;
          state_d   = ST_ENTER_A;
          err_inf_d = 1'b0;
          err_ovf_d = 1'b0;
        end else if (key_is_op) begin
`ifdef CALC_ENTRY_CHAIN_EN
          if (!err_inf_q && !err_ovf_q) begin
            a_d     = disp_q;
            b_d     = BLANK;
            op_d    = key_code;
            state_d = ST_ENTER_B;
          end
`else
          op_d = op_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ENTER_A;
      a_q       <= BLANK;
      b_q       <= BLANK;
      op_q      <= 4'h0;
      req_q     <= 1'b0;
      inf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      disp_q    <= ZERO;
      err_inf_q <= 1'b0;
      err_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      req_q     <= req_d;
      inf_q     <= inf_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
      err_inf_q <= err_inf_d;
      err_ovf_q <= err_ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign data_input = {ovf_q, inf_q, req_q, op_q, a_q, b_q};
  assign disp       = disp_q;
  assign err_inf    = err_inf_q;
  assign err_ovf    = err_ovf_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_calc_entry.sv
// Bench for calc_entry: behavioural calc core, digit-list reference model, per-cycle compare.
// Build with +define+CALC_ENTRY_CHAIN_EN to cover result chaining.

module tb_calc_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [54:0] data_input;
  logic [23:0] data_output;
  logic        flag_out;
  logic        flag_inf_out;
  logic        flag_ovf_out;
  logic [23:0] disp;
  logic        err_inf;
  logic        err_ovf;
  logic        busy;
  logic [2:0]  dbg_state;
  logic        hold_ack;
  logic        chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  calc_entry #(.DIGITS(6)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .data_input(data_input), .data_output(data_output), .flag_out(flag_out),
    .flag_inf_out(flag_inf_out), .flag_ovf_out(flag_ovf_out), .disp(disp),
    .err_inf(err_inf), .err_ovf(err_ovf), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- behavioural core ----------------
  function automatic longint dec_val(input logic [23:0] f);
    longint v = 0;
    for (int i = 5; i >= 0; i--) begin
      if (f[i*4 +: 4] != 4'hF) v = v * 10 + longint'(f[i*4 +: 4]);
    end
    return v;
  endfunction

  function automatic logic [23:0] fmt(input longint v);
    logic [23:0] r = '1;
    longint t = v;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || t != 0) r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Returns {ovf toggle, inf toggle, result digits}.
  function automatic logic [25:0] core_fn(input logic [54:0] di);
    longint a = dec_val(di[47:24]);
    longint b = dec_val(di[23:0]);
    longint r = 0;
    logic dz = 1'b0;
    logic ov = 1'b0;
    case (di[51:48])
      4'hA: if (b == 0) dz = 1'b1; else r = a / b;
      4'hB: r = a * b;
      4'hC: r = (a >= b) ? a - b : b - a;
      4'hD: r = a + b;
      default: r = 0;
    endcase
    if (r > 999999) begin
      ov = 1'b1;
      r  = r % 1000000;
    end
    return {di[54] ^ ov, di[53] ^ dz, dz ? 24'hFFFFFF : fmt(r)};
  endfunction

  logic [25:0] core_res;
  assign core_res     = core_fn(data_input);
  assign data_output  = core_res[23:0];
  assign flag_inf_out = core_res[24];
  assign flag_ovf_out = core_res[25];
  assign flag_out     = hold_ack ? data_input[52] : ~data_input[52];

  // ---------------- reference model ----------------
  localparam int M_EA = 0, M_EB = 1, M_REQ = 2, M_WAIT = 3, M_RES = 4;
  int          m_mode;
  int          m_a[$];
  int          m_b[$];
  logic [3:0]  m_op;
  logic        m_req, m_inf, m_ovf, m_ei, m_eo;
  logic [23:0] m_disp;

  function automatic logic [23:0] pack(input int q[$]);
    logic [23:0] r = '1;
    for (int i = 0; i < q.size(); i++) r[(q.size() - 1 - i) * 4 +: 4] = 4'(q[i]);
    return r;
  endfunction

  task automatic model_clear();
    m_mode = M_EA;
    m_a.delete();
    m_b.delete();
    m_op   = 4'h0;
    m_disp = 24'hFFFFF0;
    m_ei   = 1'b0;
    m_eo   = 1'b0;
  endtask

  task automatic model_step();
    logic [25:0] r;
    int k;
    logic started;
    k = int'(key_code);
    if (rst) begin
      model_clear();
      m_req = 1'b0;
      m_inf = 1'b0;
      m_ovf = 1'b0;
    end else if (m_mode == M_REQ) begin
      m_req  = ~m_req;
      m_mode = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      if (!hold_ack) begin
        r = core_fn({m_ovf, m_inf, m_req, m_op, pack(m_a), pack(m_b)});
        m_disp = r[23:0];
        if (r[24] != m_inf) begin m_ei = 1'b1; m_inf = r[24]; end
        if (r[25] != m_ovf) begin m_eo = 1'b1; m_ovf = r[25]; end
        m_mode = M_RES;
      end
    end else if (key_valid) begin
      if (k == 15) begin
        model_clear();
      end else if (k < 10) begin
        if (m_mode == M_EA) begin
          if (m_a.size() < 6) begin
            if (!(m_a.size() == 1 && m_a[0] == 0 && k == 0)) m_a.push_back(k);
            m_disp = pack(m_a);
          end
        end else if (m_mode == M_EB) begin
          if (m_b.size() < 6) begin
            if (!(m_b.size() == 1 && m_b[0] == 0 && k == 0)) m_b.push_back(k);
            m_disp = pack(m_b);
          end
        end else begin
          m_a.delete();
          m_b.delete();
          m_a.push_back(k);
          m_mode = M_EA;
          m_ei = 1'b0;
          m_eo = 1'b0;
        end
      end else if (k <= 13) begin
        if (m_mode == M_EA && m_a.size() > 0) begin
          m_op = 4'(k);
          m_mode = M_EB;
        end else if (m_mode == M_EB && m_b.size() == 0) begin
          m_op = 4'(k);
        end else if (m_mode == M_RES) begin
`ifdef CALC_ENTRY_CHAIN_EN
          if (!m_ei && !m_eo) begin
            m_a.delete();
            started = 1'b0;
            for (int i = 5; i >= 0; i--) begin
              if (started || m_disp[i*4 +: 4] != 4'hF) begin
                m_a.push_back(int'(m_disp[i*4 +: 4]));
                started = 1'b1;
              end
            end
            m_b.delete();
            m_op = 4'(k);
            m_mode = M_EB;
          end
`else
          started = 1'b0;
`endif
        end
      end else begin
        if (m_mode == M_EB && m_b.size() > 0) m_mode = M_REQ;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("disp", 64'(disp), 64'(m_disp));
      chk("err_inf", 64'(err_inf), 64'(m_ei));
      chk("err_ovf", 64'(err_ovf), 64'(m_eo));
      chk("busy", 64'(busy), 64'(m_mode == M_REQ || m_mode == M_WAIT));
      chk("data_input", 64'(data_input),
          64'({m_ovf, m_inf, m_req, m_op, pack(m_a), pack(m_b)}));
    end
  end

  // ---------------- driver ----------------
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] seq_mul[9];
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; hold_ack = 1'b0;
    seq_mul = '{4'h9, 4'h9, 4'h9, 4'hB, 4'h9, 4'h9, 4'h9, 4'h9, 4'hE};
    idle(2);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_disp", 64'(disp), 64'h0000_0000_00FF_FFF0);
    chk("rst_word", 64'(data_input), 64'h0000_FFFF_FFFF_FFFF);
    chk("rst_busy", 64'(busy), 64'd0);

    // 12 + 34
    press(4'h1); press(4'h2); press(4'hD); press(4'h3); press(4'h4); press(4'hE);
    chk("t1_busy_req", 64'(busy), 64'd1);
    chk("t1_opnds", 64'(data_input[51:0]), 64'h000D_FFFF_12FF_FF34);
    idle(1);
    chk("t1_busy_wait", 64'(busy), 64'd1);
    chk("t1_req", 64'(data_input[52]), 64'd1);
    idle(1);
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_disp", 64'(disp), 64'h0000_0000_00FF_FF46);

    // 7 / 0
    press(4'h7); press(4'hA); press(4'h0); press(4'hE); idle(2);
    chk("t2_err_inf", 64'(err_inf), 64'd1);
    chk("t2_inf_tog", 64'(data_input[53]), 64'd1);
    press(4'hF);
    chk("t2_clr_err", 64'(err_inf), 64'd0);
    chk("t2_tog_kept", 64'(data_input[53]), 64'd1);

    // 999 * 9999 twice
    for (int i = 0; i < 9; i++) press(seq_mul[i]);
    idle(2);
    chk("t3_err_ovf", 64'(err_ovf), 64'd1);
    chk("t3_ovf_tog", 64'(data_input[54]), 64'd1);
    chk("t3_disp", 64'(disp), 64'h0000_0000_0098_9001);
    for (int i = 0; i < 9; i++) press(seq_mul[i]);
    idle(2);
    chk("t3_err_ovf2", 64'(err_ovf), 64'd1);
    chk("t3_ovf_tog2", 64'(data_input[54]), 64'd0);

    // digit limit and lone zero
    press(4'hF);
    for (int i = 1; i <= 7; i++) press(4'(i));
    chk("t4_full", 64'(data_input[47:24]), 64'h0000_0000_0012_3456);
    press(4'hF); press(4'h0); press(4'h0);
    chk("t4_zero", 64'(data_input[47:24]), 64'h0000_0000_00FF_FFF0);

    // chaining
    press(4'hF);
    press(4'h5); press(4'hD); press(4'h3); press(4'hE); idle(2);
    chk("t5_first", 64'(disp), 64'h0000_0000_00FF_FFF8);
    press(4'hB); press(4'h2); press(4'hE); idle(2);
`ifdef CALC_ENTRY_CHAIN_EN
    chk("t5_chain", 64'(disp), 64'h0000_0000_00FF_FF16);
`else
    chk("t5_nochain", 64'(disp), 64'h0000_0000_00FF_FFF8);
`endif

    // reset in WAIT with keys dropped while busy
    press(4'hF);
    hold_ack = 1'b1;
    press(4'h1); press(4'hD); press(4'h2); press(4'hE);
    press(4'h7); press(4'h8);
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_dropped", 64'(data_input[47:0]), 64'h0000_FFFF_F1FF_FFF2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    hold_ack = 1'b0;
    chk("t6_word", 64'(data_input), 64'h0000_FFFF_FFFF_FFFF);
    chk("t6_disp", 64'(disp), 64'h0000_0000_00FF_FFF0);
    chk("t6_busy0", 64'(busy), 64'd0);
    chk("t6_errs", 64'({err_inf, err_ovf}), 64'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      rst       = ($urandom_range(0, 299) == 0);
      hold_ack  = ($urandom_range(0, 3) == 0);
      key_valid = ($urandom_range(0, 99) < 65);
      r = int'($urandom_range(0, 99));
      if (r < 58)      key_code = 4'($urandom_range(0, 9));
      else if (r < 76) key_code = 4'($urandom_range(10, 13));
      else if (r < 94) key_code = 4'hE;
      else             key_code = 4'hF;
      @(negedge clk);
    end
    rst = 1'b0; key_valid = 1'b0; hold_ack = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
